// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Round-robin two-port arbiter and access sequencer for the data
//            RAM / simulation UART, with alignment and range screening.
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
    parameter int unsigned RAM_SIZE  = 256,
    parameter logic [31:0] UART_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_u_b_h_w,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_fault,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_u_b_h_w,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_fault,

    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    output logic [2:0]  ram_u_b_h_w,
    input  logic [31:0] ram_dout,

    output logic        busy
);

    localparam logic [31:0] c_ram_limit = 32'(RAM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        cmd_we_q, cmd_we_d;
    logic        fault_q, fault_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_din_q, ram_din_d;
    logic [2:0]  ram_size_q, ram_size_d;
    logic        ram_we_q, ram_we_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;
    logic        p0_fault_q, p0_fault_d;
    logic        p1_fault_q, p1_fault_d;

    logic        w_grant1;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_sel_size;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_bad_uart;
    logic        w_fault;
    logic [31:0] w_rdata;

    // Port 1 wins only when alone or when port 0 was served last.
    always_comb begin
        w_grant1       = p1_req & (~p0_req | ~last_grant_q);
        w_sel_we       = w_grant1 ? p1_we      : p0_we;
        w_sel_addr     = w_grant1 ? p1_addr    : p0_addr;
        w_sel_wdata    = w_grant1 ? p1_wdata   : p0_wdata;
        w_sel_size     = w_grant1 ? p1_u_b_h_w : p0_u_b_h_w;
        w_is_word      = w_sel_size[1];
        w_is_half      = ~w_sel_size[1] & w_sel_size[0];
        w_misaligned   = (w_is_half & w_sel_addr[0]) |
                         (w_is_word & (w_sel_addr[1:0] != 2'b00));
        w_out_of_range = (w_sel_addr >= c_ram_limit) && (w_sel_addr != UART_ADDR);
        w_bad_uart     = w_sel_we && (w_sel_addr == UART_ADDR) && (w_is_word || w_is_half);
        w_fault        = w_misaligned | w_out_of_range | w_bad_uart;
        w_rdata        = (fault_q | cmd_we_q) ? 32'd0 : ram_dout;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        cmd_we_d     = cmd_we_q;
        fault_d      = fault_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_size_d   = ram_size_q;
        ram_we_d     = 1'b0;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_fault_d   = p0_fault_q;
        p1_fault_d   = p1_fault_q;

        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    port_d     = w_grant1;
                    cmd_we_d   = w_sel_we;
                    fault_d    = w_fault;
                    ram_addr_d = w_sel_addr;
                    ram_din_d  = w_sel_wdata;
                    ram_size_d = w_sel_size;
                    ram_we_d   = w_sel_we & ~w_fault;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (port_q) begin
                    p1_ack_d   = 1'b1;
                    p1_rdata_d = w_rdata;
                    p1_fault_d = fault_q;
                end else begin
                    p0_ack_d   = 1'b1;
                    p0_rdata_d = w_rdata;
                    p0_fault_d = fault_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_grant_d = port_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Asynchronous clear also drops ram_we at once, so a reset ahead of the
    // ACCESS negedge suppresses the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            cmd_we_q     <= 1'b0;
            fault_q      <= 1'b0;
            ram_addr_q   <= 32'd0;
            ram_din_q    <= 32'd0;
            ram_size_q   <= 3'd0;
            ram_we_q     <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= 32'd0;
            p1_rdata_q   <= 32'd0;
            p0_fault_q   <= 1'b0;
            p1_fault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            cmd_we_q     <= cmd_we_d;
            fault_q      <= fault_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_size_q   <= ram_size_d;
            ram_we_q     <= ram_we_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_fault_q   <= p0_fault_d;
            p1_fault_q   <= p1_fault_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign ram_we      = ram_we_q;
    assign ram_u_b_h_w = ram_size_q;
    assign p0_ack      = p0_ack_q;
    assign p1_ack      = p1_ack_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign p0_fault    = p0_fault_q;
    assign p1_fault    = p1_fault_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Directed bench for ram_port_arbiter with a byte RAM + UART model.
// Revision : 1.0
// ============================================================================
module tb_ram_port_arbiter;

    localparam logic [31:0] c_uart = 32'h1000_0000;
    localparam logic [2:0]  c_bu = 3'b100, c_b = 3'b000, c_hu = 3'b101,
                            c_h  = 3'b001, c_w = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [2:0]  p0_u_b_h_w = '0;
    logic        p0_ack, p0_fault;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [2:0]  p1_u_b_h_w = '0;
    logic        p1_ack, p1_fault;
    logic [31:0] p1_rdata;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic        ram_we, busy;
    logic [2:0]  ram_u_b_h_w;

    int total = 0;
    int bad   = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_u_b_h_w(p0_u_b_h_w), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_fault(p0_fault),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_u_b_h_w(p1_u_b_h_w), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_fault(p1_fault),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_u_b_h_w(ram_u_b_h_w), .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- RAM + UART model ----------------
    logic [7:0]  mem [256];
    logic [7:0]  uart_last = 8'h00;
    int          write_count = 0;
    logic [7:0]  ra, b0, b1, b2, b3;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h80;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                write_count++;
                if (ram_addr == c_uart) begin
                    uart_last = ram_din[7:0];
                    $display("uart: %c", ram_din[7:0]);
                end else if (ram_addr < 32'd256) begin
                    mem[ram_addr[7:0]] = ram_din[7:0];
                    if (ram_u_b_h_w[1] || ram_u_b_h_w[0])
                        mem[ram_addr[7:0] + 8'd1] = ram_din[15:8];
                    if (ram_u_b_h_w[1]) begin
                        mem[ram_addr[7:0] + 8'd2] = ram_din[23:16];
                        mem[ram_addr[7:0] + 8'd3] = ram_din[31:24];
                    end
                end
            end
        end
    end

    always_comb begin
        ra = ram_addr[7:0];
        b0 = mem[ra];
        b1 = mem[ra + 8'd1];
        b2 = mem[ra + 8'd2];
        b3 = mem[ra + 8'd3];
        ram_dout = 32'd0;
        if (ram_addr < 32'd256) begin
            if (ram_u_b_h_w[1])
                ram_dout = {b3, b2, b1, b0};
            else if (ram_u_b_h_w[0])
                ram_dout = ram_u_b_h_w[2] ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            else
                ram_dout = ram_u_b_h_w[2] ? {24'd0, b0} : {{24{b0[7]}}, b0};
        end
    end

    // ---------------- monitors ----------------
    int   cyc = 0;
    logic both_err = 1'b0, idle_err = 1'b0, log_en = 1'b0;
    bit   log_port[$];
    int   log_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (p0_ack && p1_ack) both_err = 1'b1;
            if ((p0_ack || p1_ack) && !busy) idle_err = 1'b1;
            if (log_en && p0_ack) begin log_port.push_back(1'b0); log_cyc.push_back(cyc); end
            if (log_en && p1_ack) begin log_port.push_back(1'b1); log_cyc.push_back(cyc); end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size);
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_u_b_h_w = size; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_u_b_h_w = size; p0_req = 1'b1;
        end
    endtask

    // Called just after a posedge; returns the edge count until ack was seen.
    task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] size,
                           output logic [31:0] rd, output logic flt, output int lat);
        logic got;
        got = 1'b0; lat = 0; rd = '0; flt = 1'b0;
        drive(port, we, addr, wdata, size);
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge clk); #1;
            if (port ? p1_ack : p0_ack) begin
                got = 1'b1; lat = c;
                rd  = port ? p1_rdata : p0_rdata;
                flt = port ? p1_fault : p0_fault;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic port_loop(input logic port, input int n);
        logic got;
        for (int i = 0; i < n; i++) begin
            drive(port, 1'b0, 32'h10, 32'h0, c_bu);
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(posedge clk); #1;
                got = port ? p1_ack : p0_ack;
            end
            if (!got) check($sformatf("contention_timeout_p%0d", port), 32'd0, 32'd1);
            if (port) p1_req = 1'b0; else p0_req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] rd;
    logic        flt;
    int          lat, wc0, wc_before;
    logic        saw_ack;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h10,  32'h0,        c_bu, 32'h0000_0080, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        c_b,  32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h20,  32'hDEADBEEF, c_w,  32'h0,         1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h20,  32'h0,        c_w,  32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h23,  32'h0,        c_bu, 32'h0000_00DE, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h22,  32'h0,        c_hu, 32'h0000_DEAD, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h22,  32'h0,        c_h,  32'hFFFF_DEAD, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h21,  32'h0,        c_w,  32'h0,         1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h23,  32'h0,        c_h,  32'h0,         1'b1};
        vecs[9]  = '{1'b0, 1'b1, c_uart,  32'h41,       c_h,  32'h0,         1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h200, 32'h0,        c_b,  32'h0,         1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h100, 32'h0,        c_w,  32'h0,         1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'hFC,  32'h0,        c_w,  32'h0,         1'b0};
        vecs[13] = '{1'b0, 1'b1, c_uart,  32'h41,       c_b,  32'h0,         1'b0};
        vecs[14] = '{1'b1, 1'b0, c_uart,  32'h0,        c_w,  32'h0,         1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h40,  32'hCAFEF00D, c_w,  32'h0,         1'b0};
        vecs[16] = '{1'b1, 1'b1, 32'h104, 32'h55,       c_b,  32'h0,         1'b1};

        // reset values, checked with no clock edge involved
        #1 rst = 1'b1;
        #1;
        check("rst_ram_we",   {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_din",  ram_din, 32'd0);
        check("rst_ram_size", {29'd0, ram_u_b_h_w}, 32'd0);
        check("rst_acks",     {30'd0, p0_ack, p1_ack}, 32'd0);
        check("rst_rdata",    p0_rdata | p1_rdata, 32'd0);
        check("rst_faults",   {30'd0, p0_fault, p1_fault}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // contention straight out of reset: port 0 wins the first tie
        log_en = 1'b1;
        fork
            port_loop(1'b0, 4);
            port_loop(1'b1, 4);
        join
        log_en = 1'b0;
        check("contention_ack_count", log_port.size(), 32'd8);
        for (int i = 0; i < log_port.size(); i++) begin
            check($sformatf("contention_port_%0d", i), {31'd0, log_port[i]}, i % 2);
            if (i > 0)
                check($sformatf("contention_gap_%0d", i), log_cyc[i] - log_cyc[i-1], 32'd3);
        end
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            wc0 = write_count;
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                    rd, flt, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd2);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_fault", i), {31'd0, flt}, {31'd0, vecs[i].exp_fault});
            check($sformatf("vec%0d_writes", i), write_count - wc0,
                  (vecs[i].we && !vecs[i].exp_fault) ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_idle_busy", i), {31'd0, busy}, 32'd0);
        end
        check("uart_byte", {24'd0, uart_last}, 32'h41);

        // reset in the middle of a store's ACCESS cycle
        wc_before = write_count;
        drive(1'b0, 1'b1, 32'h40, 32'h12345678, c_w);
        @(posedge clk); #1;
        check("mid_access_we", {31'd0, ram_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",   {31'd0, busy}, 32'd0);
        check("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
        p0_req = 1'b0;
        saw_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack) saw_ack = 1'b1;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack) saw_ack = 1'b1;
        end
        check("mid_rst_no_ack", {31'd0, saw_ack}, 32'd0);
        check("mid_rst_no_write", write_count - wc_before, 32'd0);
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, c_w, rd, flt, lat);
        check("mid_rst_readback", rd, 32'hCAFE_F00D);
        check("mid_rst_read_lat", lat, 32'd2);

        check("ack_exclusive", {31'd0, both_err}, 32'd0);
        check("ack_not_idle",  {31'd0, idle_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
